// File: rtl/rx_pkg.sv
// Shared field widths and result-register state encoding for the rx checksum arbiter.
package rx_pkg;
   localparam int DATA_W = 7;
   localparam int CSUM_W = 3;
   localparam int WORD_W = 10;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;
endpackage

// File: rtl/rx_csum_check.sv
// Combinational checksum test: the top CSUM_W bits must equal the inverted popcount of the data field.
module rx_csum_check
   import rx_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   output logic              ok
);

   logic [CSUM_W-1:0] pc;

   always_comb begin
      pc = '0;
      for (int i = 0; i < DATA_W; i++) begin
         pc = pc + CSUM_W'(word[i]);
      end
      ok = (word[WORD_W-1:DATA_W] == ~pc);
   end

endmodule

// File: rtl/rx_check_arbiter.sv
// Two-channel round-robin arbiter feeding a one-entry checked-result register.
// Optional per-channel error counters are built only when RX_CHECK_ERR_CNT_EN is defined.
module rx_check_arbiter
   import rx_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [WORD_W-1:0] req0_word,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [WORD_W-1:0] req1_word,
   output logic              req1_ready,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_ok,
   output logic              res_src,
   input  logic              err_clr,
   output logic [CNT_W-1:0]  err_cnt0,
   output logic [CNT_W-1:0]  err_cnt1
);

   state_t            state_q, state_d;
   logic              last_grant_q;
   logic              grant;
   logic              can_accept;
   logic              accept;
   logic [WORD_W-1:0] word_sel;
   logic              ok_sel;

   // On a tie the channel not granted last wins; a lone requester always wins.
   always_comb begin
      if (req0_valid && req1_valid) grant = ~last_grant_q;
      else                          grant = req1_valid;
   end

   assign can_accept = (state_q == EMPTY) || res_ready;
   assign accept     = rst_n && can_accept && (req0_valid || req1_valid);
   assign req0_ready = accept && !grant;
   assign req1_ready = accept && grant;
   assign word_sel   = grant ? req1_word : req0_word;

   rx_csum_check u_csum (
      .word (word_sel),
      .ok   (ok_sel)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (accept) state_d = FULL;
         FULL:    if (res_ready && !accept) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= EMPTY;
         last_grant_q <= 1'b1;
         res_data     <= '0;
         res_ok       <= 1'b0;
         res_src      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            last_grant_q <= grant;
            res_data     <= word_sel[DATA_W-1:0];
            res_ok       <= ok_sel;
            res_src      <= grant;
         end
      end
   end

   assign res_valid = (state_q == FULL);

`ifdef RX_CHECK_ERR_CNT_EN
   logic [CNT_W-1:0] cnt0_q, cnt1_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   // Clear beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (!rst_n || err_clr) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (accept && !ok_sel) begin
         if (grant) cnt1_q <= sat_inc(cnt1_q);
         else       cnt0_q <= sat_inc(cnt0_q);
      end
   end

   assign err_cnt0 = cnt0_q;
   assign err_cnt1 = cnt1_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err_cnt0       = '0;
   assign err_cnt1       = '0;
`endif

endmodule

// File: tb/tb_rx_check_arbiter.sv
// Self-checking bench for rx_check_arbiter: directed vector table, corner sequences, random traffic vs a reference model.
module tb_rx_check_arbiter;

   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;
`ifdef RX_CHECK_ERR_CNT_EN
   localparam int CE = 1;
`else
   localparam int CE = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic [9:0]    req0_word = '0, req1_word = '0;
   logic          req0_ready, req1_ready;
   logic          res_valid, res_ready = 1'b0;
   logic [6:0]    res_data;
   logic          res_ok, res_src;
   logic          err_clr = 1'b0;
   logic [CW-1:0] err_cnt0, err_cnt1;

   int checks = 0;
   int errors = 0;

   // Reference state: the held result, who went last, error totals
   bit       m_full;
   bit [6:0] m_data;
   bit       m_ok, m_src, m_last;
   int       m_c0, m_c1;

   rx_check_arbiter #(.CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_word  (req0_word),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_word  (req1_word),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_ok     (res_ok),
      .res_src    (res_src),
      .err_clr    (err_clr),
      .err_cnt0   (err_cnt0),
      .err_cnt1   (err_cnt1)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   function automatic bit word_ok(input logic [9:0] w);
      int pc;
      pc = $countones(w[6:0]);
      return int'(w[9:7]) == (7 - pc);
   endfunction

   function automatic logic [9:0] good_word(input logic [6:0] d);
      int pc;
      pc = $countones(d);
      return {3'(7 - pc), d};
   endfunction

   task automatic model_reset();
      m_full = 0; m_data = '0; m_ok = 0; m_src = 0; m_last = 1; m_c0 = 0; m_c1 = 0;
   endtask

   task automatic check_outputs();
      chk("res_valid", int'(res_valid), int'(m_full));
      chk("res_data",  int'(res_data),  int'(m_data));
      chk("res_ok",    int'(res_ok),    int'(m_ok));
      chk("res_src",   int'(res_src),   int'(m_src));
      chk("err_cnt0",  int'(err_cnt0),  m_c0);
      chk("err_cnt1",  int'(err_cnt1),  m_c1);
   endtask

   // One clock: apply inputs, check readys combinationally, advance model, check registered outputs.
   task automatic drive(input bit v0, input logic [9:0] w0, input bit v1, input logic [9:0] w1,
                        input bit rr, input bit clr, output bit r0, output bit r1);
      bit g, acc, okw;
      logic [9:0] w;
      @(negedge clk);
      req0_valid = v0; req0_word = w0; req1_valid = v1; req1_word = w1;
      res_ready = rr; err_clr = clr;
      #1;
      acc = (v0 || v1) && (!m_full || rr);
      g   = (v0 && v1) ? !m_last : v1;
      r0 = req0_ready; r1 = req1_ready;
      chk("req0_ready", int'(r0), int'(acc && !g));
      chk("req1_ready", int'(r1), int'(acc && g));
      w   = g ? w1 : w0;
      okw = word_ok(w);
      if (CE != 0) begin
         if (clr) begin
            m_c0 = 0; m_c1 = 0;
         end else if (acc && !okw) begin
            if (g) m_c1 = (m_c1 < CMAX) ? m_c1 + 1 : CMAX;
            else   m_c0 = (m_c0 < CMAX) ? m_c0 + 1 : CMAX;
         end
      end
      if (acc) begin
         m_full = 1; m_data = w[6:0]; m_ok = okw; m_src = g; m_last = g;
      end else if (rr) begin
         m_full = 0;
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset(input bit v0, input bit v1);
      @(negedge clk);
      rst_n = 0; req0_valid = v0; req1_valid = v1; res_ready = 1; err_clr = 0;
      req0_word = 10'h380; req1_word = 10'h07F;
      #1;
      chk("rst_req0_ready", int'(req0_ready), 0);
      chk("rst_req1_ready", int'(req1_ready), 0);
      @(posedge clk);
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      rst_n = 1; req0_valid = 0; req1_valid = 0;
   endtask

   typedef struct {
      bit v0; logic [9:0] w0; bit v1; logic [9:0] w1; bit rr;
      bit r0; bit r1; bit valid; logic [6:0] data; bit ok; bit src; int e1;
   } vec_t;

   vec_t tbl[9];

   initial begin
      bit r0, r1;
      bit v0, v1, rr, clr;
      logic [9:0] w0, w1;

      tbl[0] = '{1'b1, 10'h1D5, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b1, 7'h55, 1'b1, 1'b0, 0};
      tbl[1] = '{1'b0, 10'h000, 1'b1, 10'h0D5, 1'b1, 1'b0, 1'b1, 1'b1, 7'h55, 1'b0, 1'b1, CE};
      tbl[2] = '{1'b1, 10'h380, 1'b1, 10'h07F, 1'b1, 1'b1, 1'b0, 1'b1, 7'h00, 1'b1, 1'b0, CE};
      tbl[3] = '{1'b1, 10'h380, 1'b1, 10'h07F, 1'b1, 1'b0, 1'b1, 1'b1, 7'h7F, 1'b1, 1'b1, CE};
      tbl[4] = '{1'b1, 10'h380, 1'b1, 10'h07F, 1'b0, 1'b0, 1'b0, 1'b1, 7'h7F, 1'b1, 1'b1, CE};
      tbl[5] = '{1'b1, 10'h380, 1'b1, 10'h07F, 1'b0, 1'b0, 1'b0, 1'b1, 7'h7F, 1'b1, 1'b1, CE};
      tbl[6] = '{1'b1, 10'h380, 1'b1, 10'h07F, 1'b0, 1'b0, 1'b0, 1'b1, 7'h7F, 1'b1, 1'b1, CE};
      tbl[7] = '{1'b1, 10'h380, 1'b1, 10'h07F, 1'b1, 1'b1, 1'b0, 1'b1, 7'h00, 1'b1, 1'b0, CE};
      tbl[8] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0, CE};

      model_reset();
      do_reset(1'b1, 1'b1);
      chk("reset_valid", int'(res_valid), 0);
      chk("reset_data",  int'(res_data), 0);

      // Good word, bad word, tie order, backpressure and same-cycle drain/refill
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].v0, tbl[i].w0, tbl[i].v1, tbl[i].w1, tbl[i].rr, 1'b0, r0, r1);
         chk($sformatf("vec%0d_r0", i),    int'(r0),        int'(tbl[i].r0));
         chk($sformatf("vec%0d_r1", i),    int'(r1),        int'(tbl[i].r1));
         chk($sformatf("vec%0d_valid", i), int'(res_valid), int'(tbl[i].valid));
         chk($sformatf("vec%0d_data", i),  int'(res_data),  int'(tbl[i].data));
         chk($sformatf("vec%0d_ok", i),    int'(res_ok),    int'(tbl[i].ok));
         chk($sformatf("vec%0d_src", i),   int'(res_src),   int'(tbl[i].src));
         chk($sformatf("vec%0d_e1", i),    int'(err_cnt1),  tbl[i].e1);
      end

      // Saturation on ch0, then clear against a same-cycle bad word
      for (int i = 0; i < 5; i++) drive(1'b1, 10'h0D5, 1'b0, 10'h000, 1'b1, 1'b0, r0, r1);
      chk("sat_err_cnt0", int'(err_cnt0), 3 * CE);
      drive(1'b1, 10'h0D5, 1'b0, 10'h000, 1'b1, 1'b1, r0, r1);
      chk("clr_err_cnt0", int'(err_cnt0), 0);
      chk("clr_err_cnt1", int'(err_cnt1), 0);

      // Reset while FULL discards the result and restores ch0 priority
      drive(1'b0, 10'h000, 1'b1, 10'h0D5, 1'b1, 1'b0, r0, r1);
      drive(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, r0, r1);
      chk("pre_rst_valid", int'(res_valid), 1);
      chk("pre_rst_cnt1",  int'(err_cnt1), CE);
      do_reset(1'b1, 1'b1);
      chk("rst_full_valid", int'(res_valid), 0);
      chk("rst_full_cnt1",  int'(err_cnt1), 0);
      drive(1'b1, 10'h380, 1'b1, 10'h07F, 1'b1, 1'b0, r0, r1);
      chk("post_rst_tie_r0", int'(r0), 1);
      chk("post_rst_tie_src", int'(res_src), 0);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         v0  = ($urandom_range(0, 1) == 1);
         v1  = ($urandom_range(0, 1) == 1);
         w0  = ($urandom_range(0, 1) == 1) ? good_word(7'($urandom)) : 10'($urandom);
         w1  = ($urandom_range(0, 1) == 1) ? good_word(7'($urandom)) : 10'($urandom);
         rr  = ($urandom_range(0, 9) < 6);
         clr = ($urandom_range(0, 15) == 0);
         drive(v0, w0, v1, w1, rr, clr, r0, r1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
